// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared opcode and state encodings for the sequential ALU family.
//            Reused by the ALU top, its sub-modules and the testbench.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation select codes (3-bit opcode field)
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_NOT = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_ADD = 3'd5;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    // Control FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_iter
// Purpose  : Iterative signed multiplier. Multiplies operand magnitudes with
//            a shift-add loop (one multiplier bit per cycle, WIDTH cycles),
//            then applies the product sign.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            i_start      - latch operands and begin (ignored while busy)
//            i_a, i_b     - signed WIDTH-bit operands
//            o_done       - high during the final iteration cycle
//            o_product    - signed 2*WIDTH-bit product, valid with o_done
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    logic                 r_busy;
    logic                 r_sign;
    logic [CNT_W-1:0]     r_count;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [2*WIDTH-1:0]   w_acc_next;

    // Magnitude kept as WIDTH-bit unsigned so -2^(WIDTH-1) maps to 2^(WIDTH-1)
    assign w_abs_a = i_a[WIDTH-1] ? (~i_a + 1'b1) : i_a;
    assign w_abs_b = i_b[WIDTH-1] ? (~i_b + 1'b1) : i_b;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Final result is taken from the accumulator value of the last step so
    // the top can register it on the same edge as that step.
    assign o_done    = r_busy && (r_count == C_LAST);
    assign o_product = r_sign ? (~w_acc_next + 1'b1) : w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_sign   <= 1'b0;
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (!r_busy) begin
            if (i_start) begin
                r_busy   <= 1'b1;
                r_sign   <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                r_count  <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                r_mplier <= w_abs_b;
                r_acc    <= '0;
            end
        end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_count == C_LAST) begin
                r_busy  <= 1'b0;
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered 8-opcode ALU with valid/ready handshakes on input and
//            output. Logic/add/sub complete in one cycle; multiply uses the
//            iterative alu_mul_iter unit (WIDTH cycles). Zero, negative and
//            overflow flags accompany each result.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid/in_ready   - operand handshake (a, b, opcode)
//            a, b                - signed WIDTH-bit operands
//            opcode              - operation select (see alu_pkg)
//            out_valid/out_ready - result handshake (z, flags)
//            z                   - 2*WIDTH-bit result
//            flag_zero/neg/ovf   - result status flags
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   z,
    output logic                 flag_zero,
    output logic                 flag_neg,
    output logic                 flag_ovf
);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [2*WIDTH-1:0]   r_z;
    logic [2*WIDTH-1:0]   w_z_next;
    logic                 r_zero;
    logic                 r_neg;
    logic                 r_ovf;
    logic                 w_ovf_next;
    logic                 w_load;

    logic                 w_accept;
    logic                 w_mul_start;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_mul_prod;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_alu_z;
    logic                 w_alu_ovf;

    assign w_accept    = in_valid && (r_state == ST_IDLE);
    assign w_mul_start = w_accept && (opcode == OP_MUL);

    // One extra bit keeps add/sub exact; overflow means the top two bits of
    // the exact result disagree, i.e. it does not fit in WIDTH bits.
    assign w_sum  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign w_diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};

    always_comb begin
        w_alu_z   = '0;
        w_alu_ovf = 1'b0;
        case (opcode)
            OP_NOT: w_alu_z = {{WIDTH{1'b0}}, ~a};
            OP_AND: w_alu_z = {{WIDTH{1'b0}}, a & b};
            OP_OR:  w_alu_z = {{WIDTH{1'b0}}, a | b};
            OP_XOR: w_alu_z = {{WIDTH{1'b0}}, a ^ b};
            OP_ADD: begin
                w_alu_z   = {{(WIDTH-1){w_sum[WIDTH]}}, w_sum};
                w_alu_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
            end
            OP_SUB: begin
                w_alu_z   = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
                w_alu_ovf = w_diff[WIDTH] ^ w_diff[WIDTH-1];
            end
            default: begin
                w_alu_z   = '0;
                w_alu_ovf = 1'b0;
            end
        endcase
    end

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (a),
        .i_b       (b),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    always_comb begin
        w_state_next = r_state;
        w_z_next     = r_z;
        w_ovf_next   = r_ovf;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (opcode == OP_MUL) begin
                        w_state_next = ST_MUL;
                    end else begin
                        w_z_next     = w_alu_z;
                        w_ovf_next   = w_alu_ovf;
                        w_load       = 1'b1;
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_z_next     = w_mul_prod;
                    w_ovf_next   = 1'b0;
                    w_load       = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_z     <= '0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_z    <= w_z_next;
                r_zero <= (w_z_next == '0);
                r_neg  <= w_z_next[2*WIDTH-1];
                r_ovf  <= w_ovf_next;
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign z         = r_z;
    assign flag_zero = r_zero;
    assign flag_neg  = r_neg;
    assign flag_ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (WIDTH=4): directed vector table
//            plus backpressure and mid-multiply reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    import alu_pkg::*;

    localparam int WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2:0]           opcode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   z;
    logic                 flag_zero;
    logic                 flag_neg;
    logic                 flag_ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .flag_zero (flag_zero),
        .flag_neg  (flag_neg),
        .flag_ovf  (flag_ovf)
    );

    typedef struct {
        logic [2:0] op;
        logic [3:0] va;
        logic [3:0] vb;
        logic [7:0] ez;
        logic       ezero;
        logic       eneg;
        logic       eovf;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one op, wait for the result, check it and release it.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [3:0] va, input logic [3:0] vb,
                          input logic [7:0] ez, input logic ezero,
                          input logic eneg, input logic eovf);
        int lat;
        int busy;
        @(negedge clk);
        check({name, " in_ready"}, int'(in_ready), 1);
        in_valid = 1'b1;
        opcode   = op;
        a        = va;
        b        = vb;
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble operands after accept; they must not affect the result
        a        = ~va;
        b        = ~vb;
        opcode   = ~op;
        lat  = 1;
        busy = 0;
        while (!out_valid && lat < 20) begin
            if (!in_ready) busy++;
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, lat, (op == OP_MUL) ? WIDTH + 1 : 1);
        if (op == OP_MUL)
            check({name, " busy cycles"}, busy, WIDTH);
        check({name, " z"}, int'(z), int'(ez));
        check({name, " flags"}, int'({flag_zero, flag_neg, flag_ovf}),
              int'({ezero, eneg, eovf}));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " back to idle"}, int'({in_ready, out_valid}), 2);
    endtask

    initial begin
        vecs[0]  = '{OP_ADD, 4'h6, 4'hD, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{OP_SUB, 4'h1, 4'h3, 8'hFE, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{OP_ADD, 4'h7, 4'h1, 8'h08, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{OP_MUL, 4'h6, 4'hD, 8'hEE, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{OP_MUL, 4'h8, 4'h8, 8'h40, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{OP_AND, 4'h6, 4'hD, 8'h04, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_OR,  4'h6, 4'hD, 8'h0F, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{OP_XOR, 4'h6, 4'hD, 8'h0B, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_NOT, 4'hC, 4'h5, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_NOP, 4'h6, 4'hD, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{OP_SUB, 4'h8, 4'h1, 8'hF7, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{OP_ADD, 4'h8, 4'h8, 8'hF0, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{OP_MUL, 4'h7, 4'h7, 8'h31, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{OP_MUL, 4'h8, 4'h7, 8'hC8, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{OP_MUL, 4'h0, 4'h5, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{OP_ADD, 4'h3, 4'hD, 8'h00, 1'b1, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        opcode    = OP_NOP;
        repeat (2) @(negedge clk);
        check("reset handshake", int'({in_ready, out_valid}), 2);
        check("reset z", int'(z), 0);
        check("reset flags", int'({flag_zero, flag_neg, flag_ovf}), 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].va, vecs[i].vb,
                   vecs[i].ez, vecs[i].ezero, vecs[i].eneg, vecs[i].eovf);
        end

        // Backpressure: result must hold and new requests must be ignored
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = OP_ADD;
        a        = 4'h2;
        b        = 4'h3;
        @(negedge clk);
        opcode = OP_SUB;
        a      = 4'h7;
        b      = 4'h1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp hold z %0d", i), int'(z), 8'h05);
            check($sformatf("bp hold hs %0d", i), int'({in_ready, out_valid}), 1);
            check($sformatf("bp hold flags %0d", i),
                  int'({flag_zero, flag_neg, flag_ovf}), 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp release", int'({in_ready, out_valid}), 2);

        // Reset while the multiplier is at count 2
        in_valid = 1'b1;
        opcode   = OP_MUL;
        a        = 4'h6;
        b        = 4'hD;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid-mul busy", int'(in_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid-mul rst hs", int'({in_ready, out_valid}), 2);
        check("mid-mul rst z", int'(z), 0);
        check("mid-mul rst flags", int'({flag_zero, flag_neg, flag_ovf}), 0);
        repeat (6) @(negedge clk);
        check("mid-mul no stale out", int'(out_valid), 0);
        run_op("post-rst add", OP_ADD, 4'h2, 4'h2, 8'h04, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
